// File: rtl/lsu_pkg.sv
// Load/store unit types: FSM states, funct3 sizes, memory NOP.
package lsu_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_WRITE,
    S_RESP,
    S_ERR_RESP
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;

  localparam logic [6:0] MEM_NOP = 7'b0;
endpackage

// File: rtl/rv_op_pkg.sv
// Shared RV32 major opcodes used on the data-memory port.
package rv_op_pkg;
  localparam logic [6:0] SW = 7'b0100011;
endpackage

// File: rtl/dmem_lsu_if.sv
// Request/response bundle from execute and the word-indexed memory port.
interface dmem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_store, req_funct3,
    output req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_store, req_funct3,
    input  req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

interface dmem_mem_if;
  logic [6:0]  mem_op;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    output mem_op, mem_addr, mem_wdata,
    input  mem_rdata
  );
  modport slave (
    input  mem_op, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/lsu_byte_lane.sv
// Lane select + extension for loads, byte/half merge for stores.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] rword,
  input  logic [15:0] sdata,
  output logic [31:0] load_val,
  output logic [31:0] merge_word
);
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = 8'h00;
    unique case (lane)
      2'd0:    b = rword[7:0];
      2'd1:    b = rword[15:8];
      2'd2:    b = rword[23:16];
      default: b = rword[31:24];
    endcase
    h = lane[1] ? rword[31:16] : rword[15:0];

    load_val   = rword;
    merge_word = rword;
    unique case (1'b1)
      size == SZ_B: begin
        load_val = {{24{sext & b[7]}}, b};
        merge_word[{lane, 3'b000} +: 8] = sdata[7:0];
      end
      size == SZ_H: begin
        load_val = {{16{sext & h[15]}}, h};
        if (lane[1]) merge_word[31:16] = sdata;
        else         merge_word[15:0]  = sdata;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit FSM; DMEM_LSU_ALIGN_CHECK_EN turns misalignment
// into an error instead of forcing natural alignment.
module dmem_lsu
  import lsu_pkg::*;
  import rv_op_pkg::*;
#(
  parameter int MEM_WORDS = 1024
) (
  input logic        clock,
  input logic        reset,
  dmem_lsu_if.slave  rq,
  dmem_mem_if.master mi
);
  state_t      state;
  logic        store_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] merge_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;

  logic        f3_ok;
  logic        range_err;
  logic        acc_err;
  logic [31:0] addr_al;
  logic [31:0] load_val;
  logic [31:0] merge_word;
`ifdef DMEM_LSU_ALIGN_CHECK_EN
  logic        misal;
`endif

  always_comb begin
    f3_ok = 1'b0;
    unique case (rq.req_funct3)
      F3_B, F3_H, F3_W: f3_ok = 1'b1;
      F3_BU, F3_HU:     f3_ok = !rq.req_store;
      default:          f3_ok = 1'b0;
    endcase
    range_err = {2'b00, rq.req_addr[31:2]} >= 32'(MEM_WORDS);
    addr_al   = rq.req_addr;
`ifdef DMEM_LSU_ALIGN_CHECK_EN
    misal = (rq.req_funct3[1:0] == 2'b01 && rq.req_addr[0])
         || (rq.req_funct3[1:0] == 2'b10 && rq.req_addr[1:0] != 2'b00);
    acc_err = !f3_ok || range_err || misal;
`else
    if (rq.req_funct3[1:0] == 2'b01)      addr_al[0]   = 1'b0;
    else if (rq.req_funct3[1:0] == 2'b10) addr_al[1:0] = 2'b00;
    acc_err = !f3_ok || range_err;
`endif
  end

  lsu_byte_lane u_lane (
    .lane       (addr_q[1:0]),
    .size       (f3_q[1:0]),
    .sext       (!f3_q[2]),
    .rword      (mi.mem_rdata),
    .sdata      (wdata_q[15:0]),
    .load_val   (load_val),
    .merge_word (merge_word)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      store_q      <= 1'b0;
      f3_q         <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= '0;
      merge_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      unique case (state)
        S_IDLE: begin
          if (rq.req_valid) begin
            store_q <= rq.req_store;
            f3_q    <= rq.req_funct3;
            addr_q  <= addr_al;
            wdata_q <= rq.req_wdata;
            if (acc_err) begin
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              state        <= S_ERR_RESP;
            end else begin
              state <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          if (!store_q) begin
            resp_rdata_q <= load_val;
            resp_valid_q <= 1'b1;
            state        <= S_RESP;
          end else if (f3_q == F3_W) begin
            resp_valid_q <= 1'b1;
            state        <= S_RESP;
          end else begin
            merge_q <= merge_word;
            state   <= S_WRITE;
          end
        end
        S_WRITE: begin
          resp_valid_q <= 1'b1;
          state        <= S_RESP;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Op depends on state so reset kills a write in the same cycle.
  assign mi.mem_op = (state == S_WRITE
                   || (state == S_ACCESS && store_q && f3_q == F3_W))
                   ? SW : MEM_NOP;
  assign mi.mem_addr  = {2'b00, addr_q[31:2]};
  assign mi.mem_wdata = (state == S_WRITE) ? merge_q : wdata_q;

  assign rq.req_ready  = (state == S_IDLE);
  assign rq.resp_valid = resp_valid_q;
  assign rq.resp_err   = resp_err_q;
  assign rq.resp_rdata = resp_rdata_q;
endmodule
